// File: rtl/auction_pkg.sv
// rtl/auction_pkg.sv - shared types and constants for the auction round controller and argmax
package auction_pkg;

    localparam int N_AGENTS    = 10;
    localparam int AGENT_IDX_W = 4;
    localparam int BID_W       = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESOLVE = 2'd2,
        AWARD   = 2'd3
    } state_t;

    // Bid bus between the round controller and the argmax, entry i = agent i
    typedef logic [N_AGENTS-1:0][BID_W-1:0] bid_arr_t;

endpackage

// File: rtl/auction_round_ctrl.sv
// rtl/auction_round_ctrl.sv - sealed-bid round controller feeding a 10-way argmax
module auction_round_ctrl
    import auction_pkg::*;
#(
    parameter int bW         = 16,
    parameter int TIMEOUT    = 64,
    parameter int ROUND_W    = 8,
    parameter int ARGMAX_LAT = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               bid_valid,
    output logic                               bid_ready,
    input  logic [AGENT_IDX_W-1:0]             bid_id,
    input  logic [bW-1:0]                      bid_val,
    output logic [N_AGENTS-1:0][bW-1:0]        bids_out,
    input  logic [AGENT_IDX_W-1:0]             win_in,
    output logic                               award_valid,
    input  logic                               award_ready,
    output logic [AGENT_IDX_W-1:0]             award_id,
    output logic [bW-1:0]                      award_bid,
    output logic                               award_none,
    output logic [ROUND_W-1:0]                 award_round,
    output logic                               busy,
    output logic                               err_bad_id
);

    // Timer counts COLLECT cycles and is reused as the RESOLVE wait counter
    localparam int TMAX = (TIMEOUT > ARGMAX_LAT + 1) ? TIMEOUT : ARGMAX_LAT + 2;
    localparam int TW   = $clog2(TMAX) + 1;

    state_t                       state_q;
    logic [N_AGENTS-1:0][bW-1:0]  bids_q;
    logic [N_AGENTS-1:0]          mask_q;
    logic [N_AGENTS-1:0]          mask_d;
    logic [TW-1:0]                timer_q;
    logic [ROUND_W-1:0]           round_q;
    logic                         bid_ready_q;
    logic                         busy_q;
    logic                         err_bad_id_q;
    logic                         award_valid_q;
    logic [AGENT_IDX_W-1:0]       award_id_q;
    logic [bW-1:0]                award_bid_q;
    logic                         award_none_q;
    logic [ROUND_W-1:0]           award_round_q;

    logic                         hs;
    logic                         id_ok;
    logic [N_AGENTS-1:0]          id_onehot;
    logic                         store;
    logic [bW-1:0]                win_bid;

    // Decode the offered bid: handshake, in-range check and first-bid-wins mask update
    always_comb begin
        hs        = bid_valid & bid_ready_q;
        id_ok     = (bid_id < AGENT_IDX_W'(N_AGENTS));
        id_onehot = id_ok ? (N_AGENTS'(1) << bid_id) : '0;
        store     = hs & (|(id_onehot & ~mask_q));
        mask_d    = store ? (mask_q | id_onehot) : mask_q;
        win_bid   = (win_in < AGENT_IDX_W'(N_AGENTS)) ? bids_q[win_in] : '0;
    end

    // Round FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            bids_q        <= '0;
            mask_q        <= '0;
            timer_q       <= '0;
            round_q       <= '0;
            bid_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            err_bad_id_q  <= 1'b0;
            award_valid_q <= 1'b0;
            award_id_q    <= '0;
            award_bid_q   <= '0;
            award_none_q  <= 1'b0;
            award_round_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bids_q      <= '0;
                        mask_q      <= '0;
                        timer_q     <= '0;
                        bid_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= COLLECT;
                    end
                end
                COLLECT: begin
                    timer_q <= timer_q + 1'b1;
                    mask_q  <= mask_d;
                    for (int i = 0; i < N_AGENTS; i++) begin
                        if (store && id_onehot[i]) begin
                            bids_q[i] <= bid_val;
                        end
                    end
                    if (hs && !id_ok) begin
                        err_bad_id_q <= 1'b1;
                    end
                    if ((&mask_d) || (timer_q == TW'(TIMEOUT - 1))) begin
                        timer_q     <= '0;
                        bid_ready_q <= 1'b0;
                        state_q     <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    if (timer_q == TW'(ARGMAX_LAT)) begin
                        award_valid_q <= 1'b1;
                        award_id_q    <= win_in;
                        award_bid_q   <= win_bid;
                        award_none_q  <= (mask_q == '0);
                        award_round_q <= round_q;
                        state_q       <= AWARD;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                AWARD: begin
                    if (award_ready) begin
                        award_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        round_q       <= round_q + 1'b1;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bid_ready   = bid_ready_q;
    assign bids_out    = bids_q;
    assign busy        = busy_q;
    assign err_bad_id  = err_bad_id_q;
    assign award_valid = award_valid_q;
    assign award_id    = award_id_q;
    assign award_bid   = award_bid_q;
    assign award_none  = award_none_q;
    assign award_round = award_round_q;

endmodule

// File: tb/tb_auction_round_ctrl.sv
// tb/tb_auction_round_ctrl.sv - directed self-checking bench for auction_round_ctrl
module tb_auction_round_ctrl;
    import auction_pkg::*;

    localparam int bW      = 16;
    localparam int ROUND_W = 8;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         start;
    logic                         bid_valid;
    logic                         bid_ready;
    logic [AGENT_IDX_W-1:0]       bid_id;
    logic [bW-1:0]                bid_val;
    bid_arr_t                     bids_out;
    logic [AGENT_IDX_W-1:0]       win_in;
    logic                         award_valid;
    logic                         award_ready;
    logic [AGENT_IDX_W-1:0]       award_id;
    logic [bW-1:0]                award_bid;
    logic                         award_none;
    logic [ROUND_W-1:0]           award_round;
    logic                         busy;
    logic                         err_bad_id;

    int errors = 0;
    int checks = 0;

    // Reference argmax: one register stage, ties go to the lowest index
    logic [AGENT_IDX_W-1:0] argmax_q;
    logic                   use_override;
    logic [AGENT_IDX_W-1:0] override_val;

    function automatic logic [AGENT_IDX_W-1:0] argmax(input bid_arr_t b);
        logic [AGENT_IDX_W-1:0] idx = '0;
        logic [BID_W-1:0]       best = b[0];
        for (int i = 1; i < N_AGENTS; i++) begin
            if (b[i] > best) begin
                best = b[i];
                idx  = AGENT_IDX_W'(i);
            end
        end
        return idx;
    endfunction

    always @(posedge clk) argmax_q <= argmax(bids_out);

    assign win_in = use_override ? override_val : argmax_q;

    auction_round_ctrl #(
        .bW(bW), .TIMEOUT(64), .ROUND_W(ROUND_W), .ARGMAX_LAT(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .bid_valid(bid_valid), .bid_ready(bid_ready), .bid_id(bid_id), .bid_val(bid_val),
        .bids_out(bids_out), .win_in(win_in),
        .award_valid(award_valid), .award_ready(award_ready), .award_id(award_id),
        .award_bid(award_bid), .award_none(award_none), .award_round(award_round),
        .busy(busy), .err_bad_id(err_bad_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_bid(input int id, input int val);
        bid_valid = 1'b1;
        bid_id    = AGENT_IDX_W'(id);
        bid_val   = bW'(val);
        tick();
        bid_valid = 1'b0;
    endtask

    task automatic wait_award(input string tag);
        int n = 0;
        while (!award_valid && n < 200) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, award_valid}, 32'd1);
    endtask

    logic [AGENT_IDX_W-1:0] hold_id;
    logic [bW-1:0]          hold_bid;
    int                     close_cnt;

    initial begin
        rst = 1'b1; start = 1'b0; bid_valid = 1'b0; bid_id = '0; bid_val = '0;
        award_ready = 1'b0; use_override = 1'b0; override_val = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy",        {31'd0, busy},        32'd0);
        chk("rst_bid_ready",   {31'd0, bid_ready},   32'd0);
        chk("rst_award_valid", {31'd0, award_valid}, 32'd0);
        chk("rst_err",         {31'd0, err_bad_id},  32'd0);
        chk("rst_bids",        {31'd0, |bids_out},   32'd0);

        // Full round with ascending bids, then award backpressure
        start = 1'b1; tick(); start = 1'b0;
        chk("full_busy",      {31'd0, busy},      32'd1);
        chk("full_bid_ready", {31'd0, bid_ready}, 32'd1);
        for (int i = 0; i < N_AGENTS; i++) send_bid(i, 10 * (i + 1));
        chk("full_close", {31'd0, bid_ready}, 32'd0);
        close_cnt = 0;
        while (!award_valid && close_cnt < 10) begin
            tick();
            close_cnt++;
        end
        chk("full_latency", close_cnt, 32'd2);
        chk("full_id",    award_id,   32'd9);
        chk("full_bid",   award_bid,  32'd100);
        chk("full_round", award_round, 32'd0);
        chk("full_none",  {31'd0, award_none}, 32'd0);
        hold_id = award_id; hold_bid = award_bid;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", {31'd0, award_valid}, 32'd1);
            chk("bp_id",    award_id,  32'd9);
            chk("bp_bid",   award_bid, 32'd100);
        end
        award_ready = 1'b1; tick(); award_ready = 1'b0;
        chk("bp_drop", {31'd0, award_valid}, 32'd0);
        chk("bp_idle", {31'd0, busy},        32'd0);

        // Timeout with a single bid
        start = 1'b1; tick(); start = 1'b0;
        send_bid(3, 500);
        for (int i = 0; i < 62; i++) tick();
        chk("to_still_open", {31'd0, bid_ready}, 32'd1);
        tick();
        chk("to_closed", {31'd0, bid_ready}, 32'd0);
        for (int i = 0; i < N_AGENTS; i++)
            chk("to_bids", bids_out[i], (i == 3) ? 32'd500 : 32'd0);
        tick(); tick();
        chk("to_valid", {31'd0, award_valid}, 32'd1);
        chk("to_id",    award_id,    32'd3);
        chk("to_bid",   award_bid,   32'd500);
        chk("to_round", award_round, 32'd1);
        award_ready = 1'b1; tick(); award_ready = 1'b0;

        // Duplicate and out-of-range IDs; start during handshake is ignored
        start = 1'b1; tick(); start = 1'b0;
        send_bid(2, 7);
        send_bid(2, 900);
        send_bid(12, 5);
        chk("dup_stored", bids_out[2], 32'd7);
        chk("bad_err",    {31'd0, err_bad_id}, 32'd1);
        wait_award("dup_wait");
        chk("dup_id",    award_id,    32'd2);
        chk("dup_bid",   award_bid,   32'd7);
        chk("dup_round", award_round, 32'd2);
        award_ready = 1'b1; start = 1'b1; tick(); award_ready = 1'b0; start = 1'b0;
        chk("hs_start_ignored", {31'd0, busy}, 32'd0);
        tick();
        chk("hs_start_still_idle", {31'd0, busy}, 32'd0);
        chk("bad_err_sticky", {31'd0, err_bad_id}, 32'd1);

        // No bids at all, winner index forced by the bench
        use_override = 1'b1; override_val = 4'd7;
        start = 1'b1; tick(); start = 1'b0;
        wait_award("none_wait");
        chk("none_flag",  {31'd0, award_none}, 32'd1);
        chk("none_bid",   award_bid,   32'd0);
        chk("none_id",    award_id,    32'd7);
        chk("none_round", award_round, 32'd3);
        award_ready = 1'b1; tick(); award_ready = 1'b0;
        use_override = 1'b0;

        // Reset mid-COLLECT, then a clean round
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) send_bid(i, 40 + i);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mrst_busy",  {31'd0, busy},        32'd0);
        chk("mrst_bids",  {31'd0, |bids_out},   32'd0);
        chk("mrst_valid", {31'd0, award_valid}, 32'd0);
        chk("mrst_err",   {31'd0, err_bad_id},  32'd0);
        tick(); tick();
        chk("mrst_no_award", {31'd0, award_valid}, 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        send_bid(0, 5); send_bid(1, 1); send_bid(2, 8); send_bid(3, 3); send_bid(4, 99);
        send_bid(5, 2); send_bid(6, 0); send_bid(7, 7); send_bid(8, 6); send_bid(9, 4);
        chk("clean_close", {31'd0, bid_ready}, 32'd0);
        wait_award("clean_wait");
        chk("clean_id",    award_id,    32'd4);
        chk("clean_bid",   award_bid,   32'd99);
        chk("clean_round", award_round, 32'd0);
        chk("clean_none",  {31'd0, award_none}, 32'd0);
        award_ready = 1'b1; tick(); award_ready = 1'b0;
        chk("clean_done", {31'd0, award_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
